mult_datapath: RTL and testbench
================================

// Module: mult_datapath
// PURPOSE
//  Sequential shift-and-add unsigned multiplier: datapath registers plus control FSM in one block.
//  Captures two N/M-bit operands on start and iterates one multiplier bit per clock.
//  Presents the full N+M-bit product with a one-cycle done pulse.
//  Sits between operand sources and any consumer that polls done.
// PARAMETERS
//  N  16  multiplicand width (bits)
//  M  16  multiplier width (bits); also the iteration count
// PORTS
//  clk           in   1    system clock; all state updates on rising edge
//  rst           in   1    asynchronous, active-low reset
//  start         in   1    request; sampled only in IDLE
//  multiplicand  in   N    unsigned operand A; captured on the accepting edge
//  multiplier    in   M    unsigned operand B; captured on the accepting edge
//  Product       out  N+M  registered product; holds value until next completion
//  done          out  1    registered completion pulse, one cycle wide
// BEHAVIOUR
//  Clocking/reset: one clock. rst is asynchronous and active-low.
//  - rst=0: state=IDLE, Product=0, done=0, accumulator/operand/counter regs=0.
//  - rst=0 mid-operation aborts the operation immediately; no done pulse is generated.
//  Registers:
//  - Mreg[N-1:0]: multiplicand.
//  - Acc[N:0]: partial high half with carry bit.
//  - Qreg[M-1:0]: multiplier, shifted to become the product low half.
//  - cnt: iteration counter, clog2(M) bits.
//  FSM states: IDLE, CALC, DONE.
//  - IDLE & start=1 (edge E0):
//    - Mreg<=multiplicand, Qreg<=multiplier, Acc<=0, cnt<=0.
//    - Next state CALC.
//  - IDLE & start=0: remain in IDLE; all outputs hold.
//  - CALC, each edge:
//    - sum = Acc + (Qreg[0] ? Mreg : 0).
//    - {Acc,Qreg} <= {sum,Qreg} >> 1, with sum N+1 bits so carry is kept.
//    - cnt <= cnt+1.
//  - CALC exit: on the M-th CALC edge (cnt==M-1, edge E0+M):
//    - Product <= final {Acc[N-1:0],Qreg}; done<=1; next state DONE.
//  - DONE, next edge: done<=0; next state IDLE.
//    - If start is still high, the next op loads on the following edge.
//    - Accept-to-accept period is M+2 clocks (18 for M=16).
//  Latency: done high and Product valid M clocks after the accepting edge (16 by default).
//  Operand capture: start and operand changes are ignored outside IDLE; operands are sampled once.
//  Arithmetic: unsigned only; product is exact and full width, so no overflow.
//  - Max case: (2^N-1)*(2^M-1).
//  Product changes only on the completion edge (or reset). It is stable between completions.
// CONFIGURATION
//  MULT_ZERO_SKIP_EN
//  - Defined: if multiplicand==0 or multiplier==0 at the accepting edge, the next edge goes straight to completion.
//    - Product<=0, done<=1, then DONE->IDLE as usual. Latency is 1 clock for zero operands.
//    - Non-zero operands behave exactly as without the macro.
//  - Undefined: every operation takes M CALC cycles, including zero operands.
// TESTING
//  - Reset: rst=0 with random inputs -> Product=0, done=0 at once (asynchronous), state IDLE.
//  - 3*5, start pulsed 1 cycle -> done=1 exactly 16 clocks after accept.
//    - Product=32'd15. done low the next cycle.
//  - 0xFFFF*0xFFFF -> Product=32'hFFFE0001 at latency 16.
//    - Also 0x8000*0x0002 -> 32'h00010000.
//  - start held high:
//    - ops 100*200 then 1234*4321 (operands changed mid-CALC must be ignored).
//    - Results 20000 then 5332114; done pulses 18 clocks apart.
//  - Reset mid-op: rst=0 at CALC cycle 8 -> no done pulse, Product=0.
//    - After release a fresh 7*9 gives 63.
//  - 0*1234 -> Product=0: latency 16 without MULT_ZERO_SKIP_EN, latency 1 with it.

Source files
------------

// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
//   Sequential shift-and-add unsigned multiplier.
//   Operands are captured when start is seen in IDLE. One multiplier bit is
//   retired per clock. The full N+M-bit product is presented with a
//   single-cycle done pulse.
//
// Parameters
//   N  multiplicand width (bits)
//   M  multiplier width (bits); also the iteration count (M >= 2)
//
// Ports
//   clk           in   1    system clock, rising edge
//   rst           in   1    asynchronous reset, active low
//   start         in   1    operation request, sampled only in IDLE
//   multiplicand  in   N    unsigned operand A
//   multiplier    in   M    unsigned operand B
//   Product       out  N+M  registered product, held until next completion
//   done          out  1    registered one-cycle completion pulse
//
// Configuration
//   MULT_ZERO_SKIP_EN  when defined, a zero operand at the accepting edge
//                      completes on the next edge with Product = 0.
// -----------------------------------------------------------------------------
module mult_datapath #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [M-1:0]     multiplier,
  output logic [N+M-1:0]   Product,
  output logic             done
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [N-1:0]       mreg_q;
  logic [N:0]         acc_q;
  logic [M-1:0]       qreg_q;
  logic [CW-1:0]      cnt_q;
  logic [N+M-1:0]     product_q;
  logic               done_q;
`ifdef MULT_ZERO_SKIP_EN
  logic               zero_q;
`endif

  logic [N:0]         addend_s;
  logic [N:0]         sum_s;
  logic [N:0]         acc_d;
  logic [M-1:0]       qreg_d;
  logic [N+M-1:0]     product_d;

  // One shift-and-add step: add Mreg when the current multiplier bit is set,
  // then shift {sum,Qreg} right by one. The carry in sum[N] lands in Acc[N-1].
  always_comb begin
    addend_s  = {(N+1){1'b0}};
    if (qreg_q[0]) begin
      addend_s = {1'b0, mreg_q};
    end else begin
      addend_s = {(N+1){1'b0}};
    end
    sum_s     = acc_q + addend_s;
    acc_d     = {1'b0, sum_s[N:1]};
    qreg_d    = {sum_s[0], qreg_q[M-1:1]};
    product_d = {acc_d[N-1:0], qreg_d};
  end

  // Control FSM together with the datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mreg_q    <= {N{1'b0}};
      acc_q     <= {(N+1){1'b0}};
      qreg_q    <= {M{1'b0}};
      cnt_q     <= {CW{1'b0}};
      product_q <= {(N+M){1'b0}};
      done_q    <= 1'b0;
`ifdef MULT_ZERO_SKIP_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mreg_q  <= multiplicand;
            qreg_q  <= multiplier;
            acc_q   <= {(N+1){1'b0}};
            cnt_q   <= {CW{1'b0}};
            state_q <= CALC;
`ifdef MULT_ZERO_SKIP_EN
            zero_q  <= (multiplicand == {N{1'b0}}) || (multiplier == {M{1'b0}});
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
`ifdef MULT_ZERO_SKIP_EN
          if (zero_q) begin
            product_q <= {(N+M){1'b0}};
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
`endif
            acc_q  <= acc_d;
            qreg_q <= qreg_d;
            cnt_q  <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            // Last multiplier bit retired this edge: publish the final value.
            if (cnt_q == CNT_LAST) begin
              product_q <= product_d;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              state_q   <= CALC;
            end
`ifdef MULT_ZERO_SKIP_EN
          end
`endif
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Product = product_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mult_datapath.sv
// -----------------------------------------------------------------------------
// tb_mult_datapath
//   Randomized self-checking bench for mult_datapath. Expected products come
//   from plain integer multiplication. Expected latency comes from the
//   operation timing rules, counted in clock edges after the accepting edge.
// -----------------------------------------------------------------------------
module tb_mult_datapath;

  localparam int N = 16;
  localparam int M = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [N-1:0]     multiplicand;
  logic [M-1:0]     multiplier;
  logic [N+M-1:0]   Product;
  logic             done;

  int checks = 0;
  int errors = 0;

  mult_datapath #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .Product      (Product),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int exp_latency(input logic [N-1:0] a, input logic [M-1:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return M;
  endfunction

  // One full operation with a single-cycle start pulse. Operands are
  // scrambled after acceptance to confirm they were captured only once.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [M-1:0] b);
    logic [N+M-1:0] prev;
    logic [N+M-1:0] exp;
    int lat;
    exp  = (N+M)'(a) * (N+M)'(b);
    @(negedge clk);
    prev         = Product;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = M'($urandom);
    lat = 0;
    check({tag, "_hold_prev"}, 64'(Product), 64'(prev));
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      multiplicand = N'($urandom);
      multiplier   = M'($urandom);
      start        = 1'($urandom);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_latency(a, b)));
    check({tag, "_product"}, 64'(Product), 64'(exp));
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done), 64'd0);
    check({tag, "_prod_stable"}, 64'(Product), 64'(exp));
  endtask

  initial begin
    int n;
    int dcount;
    logic [N-1:0] ra;
    logic [M-1:0] rb;

    // Reset with random inputs toggling.
    rst          = 1'b0;
    start        = 1'($urandom);
    multiplicand = N'($urandom);
    multiplier   = M'($urandom);
    #1;
    check("reset_product", 64'(Product), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (3) begin
      @(negedge clk);
      start        = 1'($urandom);
      multiplicand = N'($urandom);
      multiplier   = M'($urandom);
    end
    check("reset_product_held", 64'(Product), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_op("3x5", 16'd3, 16'd5);
    run_op("max", 16'hFFFF, 16'hFFFF);
    run_op("8000x2", 16'h8000, 16'h0002);

    // start held high: back-to-back operations, second operands presented mid-CALC.
    @(negedge clk);
    multiplicand = 16'd100;
    multiplier   = 16'd200;
    start        = 1'b1;
    @(negedge clk);
    multiplicand = 16'd1234;
    multiplier   = 16'd4321;
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("held_first_latency", 64'(n), 64'd16);
    check("held_first_product", 64'(Product), 64'd20000);
    while (done === 1'b1 && n < 80) begin @(negedge clk); n++; end
    while (done !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    check("held_second_at", 64'(n), 64'd34);
    check("held_second_product", 64'(Product), 64'd5332114);
    start = 1'b0;
    @(negedge clk);
    check("held_done_low", 64'(done), 64'd0);

    // Reset in the middle of CALC aborts without a done pulse.
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_product", 64'(Product), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("midreset_no_done", 64'(dcount), 64'd0);
    check("midreset_product_after", 64'(Product), 64'd0);
    run_op("7x9", 16'd7, 16'd9);

    // Zero operands.
    run_op("0x1234", 16'd0, 16'd1234);
    run_op("1234x0", 16'd1234, 16'd0);

    // Randomized operations, biased toward boundary values.
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 16'd0;
        1: ra = 16'hFFFF;
        default: ra = N'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = 16'd1;
        1: rb = 16'hFFFF;
        default: rb = M'($urandom);
      endcase
      run_op("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
